// File: rtl/wavetable_server.sv
// rtl/wavetable_server.sv - per-frame wavetable lookup for NCO voices with a shared single-port RAM
// Snapshots voice phase/wave on frame_start, reads one voice per cycle, publishes all samples at once.
module wavetable_server #(
    parameter int VOICES   = 4,
    parameter int PHASE_W  = 7,
    parameter int WAVE_W   = 2,
    parameter int SAMPLE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic [VOICES*PHASE_W-1:0]    phase_in,
    input  logic [VOICES*WAVE_W-1:0]     wave_sel,
    input  logic                         wr_en,
    input  logic [WAVE_W+PHASE_W-1:0]    wr_addr,
    input  logic [SAMPLE_W-1:0]          wr_data,
    output logic [VOICES*SAMPLE_W-1:0]   prog_sample,
    output logic                         trig_sample,
    output logic                         busy,
    output logic                         overrun
);
    localparam int ADDR_W = WAVE_W + PHASE_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, PUBLISH} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [VOICES*PHASE_W-1:0]    phase_snap_q, phase_snap_d;
    logic [VOICES*WAVE_W-1:0]     wave_snap_q, wave_snap_d;
    logic [VOICES*SAMPLE_W-1:0]   shadow_q, shadow_d;
    logic                         cap_pend_q, cap_pend_d;
    logic [IDX_W-1:0]             cap_idx_q, cap_idx_d;
    logic [VOICES*SAMPLE_W-1:0]   prog_sample_q, prog_sample_d;
    logic                         trig_q, trig_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;

    logic                         rd_en;
    logic [ADDR_W-1:0]            rd_addr;
    logic [SAMPLE_W-1:0]          mem_q [DEPTH];
    logic [SAMPLE_W-1:0]          rd_data_q;

    // Writes own the single RAM port; the FSM never asserts rd_en in a write cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        phase_snap_d  = phase_snap_q;
        wave_snap_d   = wave_snap_q;
        shadow_d      = shadow_q;
        cap_pend_d    = 1'b0;
        cap_idx_d     = cap_idx_q;
        prog_sample_d = prog_sample_q;
        trig_d        = 1'b0;
        overrun_d     = overrun_q;
        rd_en         = 1'b0;
        rd_addr       = {wave_snap_q[int'(idx_q)*WAVE_W +: WAVE_W],
                         phase_snap_q[int'(idx_q)*PHASE_W +: PHASE_W]};

        // Read data lands one cycle after issue, even if this cycle is stalled by a write.
        if (cap_pend_q) begin
            shadow_d[int'(cap_idx_q)*SAMPLE_W +: SAMPLE_W] = rd_data_q;
        end
        if (frame_start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    phase_snap_d = phase_in;
                    wave_snap_d  = wave_sel;
                    idx_d        = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (!wr_en) begin
                    rd_en      = 1'b1;
                    cap_pend_d = 1'b1;
                    cap_idx_d  = idx_q;
                    if (idx_q == IDX_W'(VOICES - 1)) begin
                        idx_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                prog_sample_d = shadow_d;
                trig_d        = 1'b1;
                state_d       = PUBLISH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SCAN) || (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            phase_snap_q  <= '0;
            wave_snap_q   <= '0;
            shadow_q      <= '0;
            cap_pend_q    <= 1'b0;
            cap_idx_q     <= '0;
            prog_sample_q <= '0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            phase_snap_q  <= phase_snap_d;
            wave_snap_q   <= wave_snap_d;
            shadow_q      <= shadow_d;
            cap_pend_q    <= cap_pend_d;
            cap_idx_q     <= cap_idx_d;
            prog_sample_q <= prog_sample_d;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign prog_sample = prog_sample_q;
    assign trig_sample = trig_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_wavetable_server.sv
// tb/tb_wavetable_server.sv - directed bench for wavetable_server with a frame-level reference model
module tb_wavetable_server;
    localparam int V = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic [V*7-1:0] phase_in;
    logic [V*2-1:0] wave_sel;
    logic          wr_en;
    logic [8:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [V*8-1:0] prog_sample;
    logic          trig_sample;
    logic          busy;
    logic          overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fs_cyc;

    wavetable_server #(.VOICES(V), .PHASE_W(7), .WAVE_W(2), .SAMPLE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .phase_in(phase_in),
        .wave_sel(wave_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_sample(prog_sample), .trig_sample(trig_sample), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is a snapshot, VOICES reads on non-write cycles, then publish.
    logic [7:0]     m_mem [512];
    logic [6:0]     m_ph [V];
    logic [1:0]     m_ws [V];
    logic [7:0]     m_samp [V];
    bit             m_active, m_pub;
    int             m_n;
    logic [V*8-1:0] e_prog;
    logic           e_trig, e_busy, e_ovr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_pub = 0; m_n = 0;
            e_prog = '0; e_trig = 0; e_busy = 0; e_ovr = 0;
        end else begin
            e_trig = 0;
            if (frame_start && m_active) e_ovr = 1;
            if (m_active) begin
                if (m_pub) begin
                    m_active = 0;
                end else if (m_n < V) begin
                    if (!wr_en) begin
                        m_samp[m_n] = m_mem[{m_ws[m_n], m_ph[m_n]}];
                        m_n++;
                    end
                end else begin
                    for (int v = 0; v < V; v++) e_prog[v*8 +: 8] = m_samp[v];
                    e_trig = 1;
                    m_pub  = 1;
                end
            end else if (frame_start) begin
                for (int v = 0; v < V; v++) begin
                    m_ph[v] = phase_in[v*7 +: 7];
                    m_ws[v] = wave_sel[v*2 +: 2];
                end
                m_active = 1; m_pub = 0; m_n = 0;
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
            e_busy = m_active && !m_pub;
        end
    end

    always @(negedge clk) begin
        chk("prog_sample", 64'(prog_sample), 64'(e_prog));
        chk("trig_sample", 64'(trig_sample), 64'(e_trig));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("overrun", 64'(overrun), 64'(e_ovr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [V*7-1:0] ph, input logic [V*2-1:0] ws);
        frame_start = 1'b1;
        phase_in    = ph;
        wave_sel    = ws;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_trig(input string name, input int exp_lat, input logic [V*8-1:0] exp_prog);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (trig_sample) begin
                seen = 1;
                chk({name, "_latency"}, 64'(cyc - fs_cyc), 64'(exp_lat));
                chk({name, "_samples"}, 64'(prog_sample), 64'(exp_prog));
            end
        end
        if (!seen) chk({name, "_trig_timeout"}, 64'd0, 64'd1);
        #1;
    endtask

    task automatic no_trig(input string name, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (trig_sample) cnt++;
        end
        chk(name, 64'(cnt), 64'd0);
        #1;
    endtask

    localparam logic [V*7-1:0] PH1 = {7'd127, 7'd64, 7'd1, 7'd0};

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; phase_in = '0; wave_sel = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset_prog", 64'(prog_sample), 64'd0);
        chk("reset_trig", 64'(trig_sample), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        #1 rst_n = 1'b1;
        tick();

        // Test 1: load wave 0 with p ^ 5A and scan four voices
        for (int p = 0; p < 128; p++) begin
            wr_en = 1'b1; wr_addr = {2'd0, 7'(p)}; wr_data = 8'(p) ^ 8'h5A;
            tick();
        end
        wr_addr = {2'd1, 7'd10}; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        tick();
        start_frame(PH1, '0);
        @(negedge clk);
        chk("busy_in_scan", 64'(busy), 64'd1);
        #1;
        wait_trig("t1", 6, 32'h251A_5B5A);
        tick();

        // Test 2: two writes to unused wave 3 stall the scan twice
        start_frame(PH1, '0);
        tick();
        wr_en = 1'b1; wr_addr = {2'd3, 7'd5}; wr_data = 8'hEE;
        tick();
        wr_addr = {2'd3, 7'd6};
        tick();
        wr_en = 1'b0;
        wait_trig("t2", 8, 32'h251A_5B5A);
        tick();

        // Test 3: write {1,10}=C3 on the frame_start cycle, voice 0 reads it the next cycle
        wr_en = 1'b1; wr_addr = {2'd1, 7'd10}; wr_data = 8'hC3;
        start_frame({7'd2, 7'd1, 7'd0, 7'd10}, {2'd0, 2'd0, 2'd0, 2'd1});
        wr_en = 1'b0;
        wait_trig("t3", 6, 32'h585B_5AC3);
        tick();

        // Test 4: frame_start two cycles into the scan is ignored and flags overrun
        start_frame(PH1, '0);
        tick();
        frame_start = 1'b1; phase_in = {7'd3, 7'd3, 7'd3, 7'd3};
        tick();
        frame_start = 1'b0;
        wait_trig("t4", 6, 32'h251A_5B5A);
        no_trig("t4_single_trig", 10);
        chk("t4_overrun_sticky", 64'(overrun), 64'd1);
        start_frame({7'd3, 7'd2, 7'd1, 7'd0}, '0);
        wait_trig("t4_next", 6, 32'h5958_5B5A);
        tick();

        // Test 5: phase_in churns during the scan; snapshot must win
        start_frame({7'd0, 7'd1, 7'd64, 7'd127}, '0);
        for (int i = 0; i < 4; i++) begin
            phase_in = 28'($urandom);
            wave_sel = 8'($urandom);
            tick();
        end
        wait_trig("t5", 6, 32'h5A5B_1A25);
        tick();

        // Test 6: one-cycle reset mid-scan aborts the frame
        start_frame(PH1, '0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_prog", 64'(prog_sample), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_overrun", 64'(overrun), 64'd0);
        tick();
        rst_n = 1'b1;
        no_trig("t6_no_trig", 10);
        start_frame(PH1, '0);
        wait_trig("t6_after", 6, 32'h251A_5B5A);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
